// File: rtl/dma_ram_pkg.sv
// Shared constants and byte-merge helper for the dma_ram_mp memory model.
package dma_ram_pkg;

  localparam int MAX_RD_LAT = 4;

  // One byte lane of a masked write: take the new byte when its enable is set.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dma_ram_rdpipe.sv
// RD_LAT-stage {valid,data} shift register; latency RD_LAT edges from i_vld to o_vld.
// No backpressure: one entry per cycle; data lanes only load behind a valid so o_dat holds.
module dma_ram_rdpipe #(
  parameter int DATA_W = 128,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
  } rd_stage_t;

  rd_stage_t r_stage [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0].vld <= i_vld;
      if (i_vld) r_stage[0].dat <= i_dat;
      for (int i = 1; i < RD_LAT; i++) begin
        r_stage[i].vld <= r_stage[i-1].vld;
        if (r_stage[i-1].vld) r_stage[i].dat <= r_stage[i-1].dat;
      end
    end
  end

  assign o_vld = r_stage[RD_LAT-1].vld;
  assign o_dat = r_stage[RD_LAT-1].dat;

endmodule

// File: rtl/dma_ram_mp.sv
// Byte-enabled write / pipelined read RAM model with sticky out-of-range capture.
// Optional WrCnt/RdCnt saturating counters when DMA_RAM_STATS_EN is defined.
module dma_ram_mp
  import dma_ram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [DATA_W-1:0]   WrData,
  input  logic [DATA_W/8-1:0] WrBe,
  input  logic                RdEn,
  input  logic [ADDR_W-1:0]   RdAddr,
  output logic [DATA_W-1:0]   RdData,
  output logic                RdValid,
  output logic                AddrErr,
  output logic [ADDR_W-1:0]   ErrAddr,
  input  logic                ErrClr
`ifdef DMA_RAM_STATS_EN
  ,
  output logic [31:0]         WrCnt,
  output logic [31:0]         RdCnt
`endif
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                NB      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("dma_ram_mp: RD_LAT must be within 1..MAX_RD_LAT");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_wr_inr, w_rd_inr, w_wr_do;
  logic              w_wr_oor, w_rd_oor, w_err;
  logic [ADDR_W-1:0] w_err_addr;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic [DATA_W-1:0] w_wr_word, w_rd_dat;

  assign w_wr_inr = (WrAddr < DEPTH_A);
  assign w_rd_inr = (RdAddr < DEPTH_A);
  assign w_wr_idx = WrAddr[IDX_W-1:0];
  assign w_rd_idx = RdAddr[IDX_W-1:0];
  assign w_wr_do  = WrEn & w_wr_inr;

  always_comb begin
    w_wr_word = r_mem[w_wr_idx];
    for (int b = 0; b < NB; b++) begin
      w_wr_word[8*b +: 8] = be_merge(r_mem[w_wr_idx][8*b +: 8], WrData[8*b +: 8], WrBe[b]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_do) begin
      r_mem[w_wr_idx] <= w_wr_word;
    end
  end

  // Array is sampled at the issue edge, so r_mem still holds the pre-write word here.
  always_comb begin
    w_rd_dat = '0;
    if (w_rd_inr) begin
      if ((WR_FIRST != 0) && w_wr_do && (w_wr_idx == w_rd_idx)) w_rd_dat = w_wr_word;
      else                                                      w_rd_dat = r_mem[w_rd_idx];
    end
  end

  dma_ram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (RdEn),
    .i_dat (w_rd_dat),
    .o_vld (RdValid),
    .o_dat (RdData)
  );

  assign w_wr_oor   = WrEn & ~w_wr_inr;
  assign w_rd_oor   = RdEn & ~w_rd_inr;
  assign w_err      = w_wr_oor | w_rd_oor;
  assign w_err_addr = w_wr_oor ? WrAddr : RdAddr;

  // A clear on the same edge as a new error still records the new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (ErrClr) begin
      r_err      <= w_err;
      r_err_addr <= w_err ? w_err_addr : '0;
    end else if (w_err && !r_err) begin
      r_err      <= 1'b1;
      r_err_addr <= w_err_addr;
    end
  end

  assign AddrErr = r_err;
  assign ErrAddr = r_err_addr;

`ifdef DMA_RAM_STATS_EN
  logic [31:0] r_wr_cnt, r_rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_do && (|WrBe) && (r_wr_cnt != 32'hFFFF_FFFF)) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (RdValid && (r_rd_cnt != 32'hFFFF_FFFF))            r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign WrCnt = r_wr_cnt;
  assign RdCnt = r_rd_cnt;
`endif

endmodule

// File: doc/dma_ram_mp.md
Name: dma_ram_mp

Overview:
- Parametrised successor to the single-port-pair simulation RAM used by the PCIe DMA testbench.
- Provides one write port with byte enables and one read port with a configurable read-latency pipeline and a valid strobe.
- Flags out-of-range accesses with a sticky error.
- Acts as the host/device memory model behind the DMA engine in simulation; must also be synthesizable.

Parameters:
DATA_W, 128, data word width in bits; multiple of 8
DEPTH, 128, number of words
ADDR_W, 32, width of address ports
RD_LAT, 1, read latency in cycles, legal range 1..4
WR_FIRST, 0, 1 = same-address read returns new write data, 0 = returns old data

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
WrEn  in  1  write strobe
WrAddr  in  ADDR_W  write word address
WrData  in  DATA_W  write data
WrBe  in  DATA_W/8  byte enables; bit i covers WrData[8i+7:8i]
RdEn  in  1  read strobe
RdAddr  in  ADDR_W  read word address
RdData  out  DATA_W  read data
RdValid  out  1  RdData valid this cycle
AddrErr  out  1  sticky out-of-range flag
ErrAddr  out  ADDR_W  address of first out-of-range access
ErrClr  in  1  clears AddrErr and ErrAddr

Behaviour:
- Reset (async assert, sync release): all memory words = 0, RdData = 0, RdValid = 0, AddrErr = 0, ErrAddr = 0, read pipeline flushed.
- Write: at a clk edge with WrEn=1 and WrAddr<DEPTH, update each byte whose WrBe bit is 1. Bytes with WrBe=0 are unchanged. WrBe=0 is a legal no-op write.
- Read: a clk edge with RdEn=1 issues a read. After exactly RdLat edges, RdValid=1 and RdData=word. Sustained one read per cycle, no stalls, no backpressure.
- RdData holds its last value when RdValid=0. It is never zeroed except by reset.
- Pipeline: RD_LAT-stage shift of {valid, data}. Array read is taken at stage 1. RD_LAT=1 matches the legacy single-register read.
- Collision (WrEn and RdEn both asserted, same in-range address, same edge):
  - WR_FIRST=1: returned data is the merged new word, honouring WrBe per byte.
  - WR_FIRST=0: returned data is the pre-write word.
- Writes issued while an earlier read is still in the pipeline do not affect that read's data.
- Out-of-range (address >= DEPTH on an enabled port):
  - Write is dropped.
  - Read still produces RdValid with RdData=0.
  - AddrErr is set and ErrAddr captures the offending address only if AddrErr was 0.
  - If both ports are out of range on the same edge, ErrAddr takes WrAddr.
- ErrClr=1 at an edge clears AddrErr and ErrAddr. If a new error occurs on the same edge, the new error wins: AddrErr=1 and ErrAddr=new address.
- Only the low ceil(log2(DEPTH)) bits index the array after the range check.
- Reset asserted mid-burst: in-flight reads are discarded, RdValid drops to 0 immediately (async).

Optional Feature:
- Macro: DMA_RAM_STATS_EN
- Defined: adds outputs WrCnt[31:0] and RdCnt[31:0], both reset to 0.
  - WrCnt increments on each in-range write with any WrBe bit set.
  - RdCnt increments on each RdValid cycle.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
  - ErrClr does not affect them.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package dma_ram_pkg holds:
  - MAX_RD_LAT=4
  - typedef rd_stage_t (valid + data, parametrised via DATA_W in module)
  - function be_merge(old, new, be)
- Sub-module dma_ram_rdpipe implements the RD_LAT-stage valid/data shift register with async reset; instanced once.
- Array, collision logic and error capture stay in top.

Test Plan:
- Reset then read addr 5 with RD_LAT=3 -> RdValid high exactly 3 edges after RdEn, RdData=0.
- Write 0x..AABB to addr 7 with WrBe=16'h0003 over a word of all 0x11 -> read returns upper 14 bytes 0x11, low bytes BB,AA.
- Same-edge write 0xDEAD / read at addr 2, old value 0x1 -> WR_FIRST=0 returns 0x1; WR_FIRST=1 returns 0xDEAD.
- Write addr 200 with DEPTH=128 -> array unchanged, AddrErr=1, ErrAddr=200. A later read of addr 300 leaves ErrAddr=200. ErrClr clears both.
- Back-to-back reads of addrs 0..15 at RD_LAT=2, reset pulsed after 8 issues -> RdValid falls immediately, no stale data after release.
- With DMA_RAM_STATS_EN: 10 writes (2 with WrBe=0) and 6 reads -> WrCnt=8, RdCnt=6.
